// File: rtl/rga_bus_responder.sv
// rtl/rga_bus_responder.sv - Agnus RGA/DRD slot receiver: write FIFO, sync strobes, hpos
//
// Samples the RGA/DRD buses once per CCK slot. Each slot is classified as
// idle, a sync strobe or a register write. Writes are queued and presented
// on a valid/ready interface. Strobes rebuild the horizontal beam position.
//
// Optional feature macro: HPOS_TRACK_EN
//   defined   - hpos counter and long-line logic are built
//   undefined - hpos is tied to 0; strobes still pulse and never enter the FIFO
//
// Ports:
//   CLK28M       in   system clock; CCK is nominally CLK28M/8
//   RESET_N      in   async active-low reset; released synchronously inside
//   CCK          in   colour clock from Agnus, asynchronous to CLK28M
//   RGA[7:0]     in   register address, chip-register offset bits [8:1]
//   DRD[15:0]    in   chip data bus
//   wr_valid     out  FIFO head valid
//   wr_addr[7:0] out  head register address
//   wr_data[15:0]out  head write data
//   wr_ready     in   downstream takes the head when high with wr_valid
//   overflow     out  sticky: a write was dropped on a full FIFO
//   strobe       out  one-cycle pulse on a strobe slot
//   strobe_type  out  0=STREQU 1=STRVBL 2=STRHOR 3=STRLONG, held until next strobe
//   hpos[8:0]    out  reconstructed horizontal position in CCK slots

module rga_bus_responder #(
  parameter int SAMPLE_DELAY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int LINE_LEN     = 227
) (
  input  logic        CLK28M,
  input  logic        RESET_N,
  input  logic        CCK,
  input  logic [7:0]  RGA,
  input  logic [15:0] DRD,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ready,
  output logic        overflow,
  output logic        strobe,
  output logic [1:0]  strobe_type,
  output logic [8:0]  hpos
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] CNT_LOAD = (SAMPLE_DELAY > 0) ? 3'(SAMPLE_DELAY - 1) : 3'd0;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge CLK28M or negedge RESET_N) begin
    if (!RESET_N) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // CCK: two synchroniser flops plus one history flop for edge detection.
  logic [2:0] cck_sr;
  logic       fall;

  always_ff @(posedge CLK28M or negedge rst_n) begin
    if (!rst_n) cck_sr <= 3'b000;
    else        cck_sr <= {cck_sr[1:0], CCK};
  end
  assign fall = cck_sr[2] & ~cck_sr[1];

  // Sample scheduling. An edge that arrives while a sample is still pending
  // fires the old sample immediately and restarts the delay for the new one.
  logic       pending;
  logic [2:0] cnt;
  logic       fire;

  assign fire = (SAMPLE_DELAY == 0) ? fall : (pending && (cnt == 3'd0 || fall));

  always_ff @(posedge CLK28M or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      cnt     <= 3'd0;
    end else if (fall && SAMPLE_DELAY != 0) begin
      pending <= 1'b1;
      cnt     <= CNT_LOAD;
    end else if (pending) begin
      if (cnt == 3'd0) pending <= 1'b0;
      else             cnt     <= cnt - 3'd1;
    end
  end

  logic        s_vld;
  logic [7:0]  s_rga;
  logic [15:0] s_drd;

  always_ff @(posedge CLK28M or negedge rst_n) begin
    if (!rst_n) begin
      s_vld <= 1'b0;
      s_rga <= 8'hFF;
      s_drd <= 16'h0000;
    end else begin
      s_vld <= fire;
      if (fire) begin
        s_rga <= RGA;
        s_drd <= DRD;
      end
    end
  end

  // Slot classification of the registered sample.
  logic is_idle, is_strobe, push_req;

  assign is_idle   = (s_rga == 8'hFF);
  assign is_strobe = (s_rga[7:2] == 6'b000111);
  assign push_req  = s_vld && !is_idle && !is_strobe;

  always_ff @(posedge CLK28M or negedge rst_n) begin
    if (!rst_n) begin
      strobe      <= 1'b0;
      strobe_type <= 2'd0;
    end else begin
      strobe <= s_vld && is_strobe;
      if (s_vld && is_strobe) strobe_type <= s_rga[1:0];
    end
  end

  // Write FIFO with registered head outputs.
  logic [23:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [PW:0]   count, count_next, remain;
  logic          pop, push, drop, full, valid_next;
  logic [23:0]   head_d;

  assign pop        = wr_valid && wr_ready;
  assign full       = (count == FULL_CNT);
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign remain     = count - (PW + 1)'(pop);
  assign count_next = remain + (PW + 1)'(push);
  assign valid_next = (count_next != '0);

  // When nothing survives the pop, the only possible new head is the pushed word.
  always_comb begin
    head_d = mem[rd_next];
    if (remain == '0) head_d = {s_rga, s_drd};
  end

  always_ff @(posedge CLK28M) begin
    if (push) mem[wr_ptr] <= {s_rga, s_drd};
  end

  always_ff @(posedge CLK28M or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_next;
      count    <= count_next;
      wr_valid <= valid_next;
      if (push)       wr_ptr <= wr_ptr + PW'(1);
      if (valid_next) {wr_addr, wr_data} <= head_d;
      if (drop)       overflow <= 1'b1;
    end
  end

`ifdef HPOS_TRACK_EN
  localparam logic [8:0] WRAP_NORM = 9'(LINE_LEN - 1);
  localparam logic [8:0] WRAP_LONG = 9'(LINE_LEN);

  logic long_line;

  // Strobes win over the wrap; STRLONG stretches only the line that follows it.
  always_ff @(posedge CLK28M or negedge rst_n) begin
    if (!rst_n) begin
      hpos      <= 9'd0;
      long_line <= 1'b0;
    end else if (s_vld) begin
      if (is_strobe) begin
        hpos      <= 9'd0;
        long_line <= (s_rga[1:0] == 2'b11);
      end else if (hpos == (long_line ? WRAP_LONG : WRAP_NORM)) begin
        hpos      <= 9'd0;
        long_line <= 1'b0;
      end else begin
        hpos <= hpos + 9'd1;
      end
    end
  end
`else
  localparam int unused_line_len = LINE_LEN;
  assign hpos = 9'd0;
`endif

endmodule

// File: tb/tb_rga_bus_responder.sv
// tb/tb_rga_bus_responder.sv - directed self-checking bench for rga_bus_responder
`timescale 1ns/1ps

module tb_rga_bus_responder;

  localparam int SD = 2;
  localparam int FD = 4;
  localparam int LL = 227;
  // Negedge index within a slot (CCK driven low at index 0) where a write
  // first shows wr_valid: two synchroniser cycles, SD delay, sample, push.
  localparam int VALID_AT = 2 + SD + 2;

  logic        CLK28M;
  logic        RESET_N;
  logic        CCK;
  logic [7:0]  RGA;
  logic [15:0] DRD;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        overflow;
  logic        strobe;
  logic [1:0]  strobe_type;
  logic [8:0]  hpos;

  int vectors;
  int miscompares;

  int          slot_strobe_cnt;
  int          slot_valid_cnt;
  int          slot_first_valid;
  logic [7:0]  slot_addr;
  logic [15:0] slot_data;
  int          acc_strobe;
  int          acc_valid;

  rga_bus_responder #(
    .SAMPLE_DELAY(SD),
    .FIFO_DEPTH(FD),
    .LINE_LEN(LL)
  ) dut (
    .CLK28M(CLK28M),
    .RESET_N(RESET_N),
    .CCK(CCK),
    .RGA(RGA),
    .DRD(DRD),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .overflow(overflow),
    .strobe(strobe),
    .strobe_type(strobe_type),
    .hpos(hpos)
  );

  initial CLK28M = 1'b0;
  always #18 CLK28M = ~CLK28M;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] exp_hpos(input int v);
`ifdef HPOS_TRACK_EN
    return 9'(v);
`else
    return 9'(0 * v);
`endif
  endfunction

  task automatic do_reset();
    RESET_N  = 1'b0;
    CCK      = 1'b1;
    RGA      = 8'hFF;
    DRD      = 16'h0000;
    wr_ready = 1'b0;
    repeat (3) @(negedge CLK28M);
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK28M);
  endtask

  // One CCK slot: bus values set with CCK falling, CCK high again after 4 cycles.
  task automatic do_slot(input logic [7:0] a, input logic [15:0] d, input bit pop_window);
    slot_strobe_cnt  = 0;
    slot_valid_cnt   = 0;
    slot_first_valid = 0;
    RGA = a;
    DRD = d;
    CCK = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK28M);
      if (strobe) slot_strobe_cnt++;
      if (wr_valid) begin
        slot_valid_cnt++;
        if (slot_first_valid == 0) begin
          slot_first_valid = i;
          slot_addr = wr_addr;
          slot_data = wr_data;
        end
      end
      if (pop_window && i == SD + 3) wr_ready = 1'b1;
      if (pop_window && i == SD + 4) wr_ready = 1'b0;
      if (i == 4) CCK = 1'b1;
    end
  endtask

  task automatic idle_slots(input int n);
    acc_strobe = 0;
    acc_valid  = 0;
    for (int k = 0; k < n; k++) begin
      do_slot(8'hFF, 16'h0000, 1'b0);
      acc_strobe += slot_strobe_cnt;
      acc_valid  += slot_valid_cnt;
    end
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    CCK      = 1'b1;
    RGA      = 8'hFF;
    DRD      = 16'h0000;
    wr_ready = 1'b0;
    repeat (3) @(negedge CLK28M);
    vectors++;
    if ({wr_valid, overflow, strobe, strobe_type, hpos} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got valid=%b ovf=%b strobe=%b type=%0d hpos=%0d, want all 0",
               wr_valid, overflow, strobe, strobe_type, hpos);
    end
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK28M);
    vectors++;
    if ({wr_valid, wr_addr, wr_data, overflow, strobe, strobe_type, hpos} !== 37'd0) begin
      miscompares++;
      $display("FAIL reset_release: got valid=%b addr=%h data=%h ovf=%b strobe=%b type=%0d hpos=%0d, want all 0",
               wr_valid, wr_addr, wr_data, overflow, strobe, strobe_type, hpos);
    end
  endtask

  task automatic test_idle();
    wr_ready = 1'b1;
    idle_slots(10);
    vectors++;
    if (acc_strobe !== 0 || acc_valid !== 0) begin
      miscompares++;
      $display("FAIL idle_quiet: got strobe cycles=%0d valid cycles=%0d, want 0/0", acc_strobe, acc_valid);
    end
    vectors++;
    if (hpos !== exp_hpos(10)) begin
      miscompares++;
      $display("FAIL idle_hpos: got %0d, want %0d", hpos, exp_hpos(10));
    end
  endtask

  task automatic test_single_write(input string tag, input int hp);
    wr_ready = 1'b1;
    do_slot(8'hC0, 16'h0F00, 1'b0);
    vectors++;
    if (slot_first_valid !== VALID_AT || slot_valid_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s_timing: got first valid at %0d for %0d cycles, want %0d for 1",
               tag, slot_first_valid, slot_valid_cnt, VALID_AT);
    end
    vectors++;
    if (slot_addr !== 8'hC0 || slot_data !== 16'h0F00) begin
      miscompares++;
      $display("FAIL %s_data: got addr=%h data=%h, want C0/0F00", tag, slot_addr, slot_data);
    end
    vectors++;
    if (hpos !== exp_hpos(hp) || strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_hpos: got hpos=%0d strobe=%b, want %0d/0", tag, hpos, strobe, exp_hpos(hp));
    end
  endtask

  task automatic test_fill_overflow();
    wr_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      do_slot(8'h40 + 8'(k), 16'(k), 1'b0);
      if (k == 4) begin
        vectors++;
        if (overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_no_ovf_at_4: got %b, want 0", overflow);
        end
      end
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_ovf_at_5: got %b, want 1", overflow);
    end
    wr_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      vectors++;
      if (wr_valid !== 1'b1 || wr_data !== 16'(j) || wr_addr !== 8'h40 + 8'(j)) begin
        miscompares++;
        $display("FAIL fill_drain_%0d: got valid=%b addr=%h data=%h, want 1/%h/%h",
                 j, wr_valid, wr_addr, wr_data, 8'h40 + 8'(j), 16'(j));
      end
      @(negedge CLK28M);
    end
    vectors++;
    if (wr_valid !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_empty: got valid=%b ovf=%b, want 0/1", wr_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 1; k <= 4; k++) do_slot(8'h60 + 8'(k), 16'hA000 + 16'(k), 1'b0);
    do_slot(8'h65, 16'hA005, 1'b1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_ovf: got %b, want 0", overflow);
    end
    wr_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      vectors++;
      if (wr_valid !== 1'b1 || wr_data !== 16'hA000 + 16'(j)) begin
        miscompares++;
        $display("FAIL fullpop_drain_%0d: got valid=%b data=%h, want 1/%h",
                 j, wr_valid, wr_data, 16'hA000 + 16'(j));
      end
      @(negedge CLK28M);
    end
    vectors++;
    if (wr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_empty: got valid=%b, want 0", wr_valid);
    end
  endtask

  task automatic check_strobe(input string tag, input logic [7:0] a, input logic [1:0] ty);
    do_slot(a, 16'h1234, 1'b0);
    vectors++;
    if (slot_strobe_cnt !== 1 || strobe_type !== ty || slot_valid_cnt !== 0 || hpos !== 9'd0) begin
      miscompares++;
      $display("FAIL %s: got strobe cycles=%0d type=%0d valid cycles=%0d hpos=%0d, want 1/%0d/0/0",
               tag, slot_strobe_cnt, strobe_type, slot_valid_cnt, hpos, ty);
    end
  endtask

  task automatic check_hpos(input string tag, input int v);
    vectors++;
    if (hpos !== exp_hpos(v)) begin
      miscompares++;
      $display("FAIL %s: got hpos=%0d, want %0d", tag, hpos, exp_hpos(v));
    end
  endtask

  task automatic test_line_wrap();
    do_reset();
    wr_ready = 1'b1;
    idle_slots(LL - 1);
    check_hpos("wrap_last", LL - 1);
    idle_slots(1);
    check_hpos("wrap_zero", 0);
    idle_slots(5);
    check_hpos("wrap_five", 5);
    check_strobe("strhor", 8'h1E, 2'd2);
    check_strobe("strlong", 8'h1F, 2'd3);
    idle_slots(LL);
    check_hpos("long_last", LL);
    vectors++;
    if (strobe_type !== 2'd3 || acc_strobe !== 0) begin
      miscompares++;
      $display("FAIL strobe_type_hold: got type=%0d strobe cycles=%0d, want 3/0", strobe_type, acc_strobe);
    end
    idle_slots(1);
    check_hpos("long_wrap", 0);
    idle_slots(LL - 1);
    check_hpos("after_long_last", LL - 1);
    idle_slots(1);
    check_hpos("after_long_wrap", 0);
    idle_slots(3);
    check_strobe("strvbl", 8'h1D, 2'd1);
    check_strobe("strequ", 8'h1C, 2'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_ready = 1'b0;
    idle_slots(97);
    for (int k = 1; k <= 3; k++) do_slot(8'h70 + 8'(k), 16'hB000 + 16'(k), 1'b0);
    vectors++;
    if (hpos !== exp_hpos(100) || wr_valid !== 1'b1 || wr_data !== 16'hB001) begin
      miscompares++;
      $display("FAIL midreset_pre: got hpos=%0d valid=%b data=%h, want %0d/1/B001",
               hpos, wr_valid, wr_data, exp_hpos(100));
    end
    RESET_N = 1'b0;
    #2;
    vectors++;
    if (wr_valid !== 1'b0 || overflow !== 1'b0 || hpos !== 9'd0) begin
      miscompares++;
      $display("FAIL midreset_async: got valid=%b ovf=%b hpos=%0d, want 0/0/0", wr_valid, overflow, hpos);
    end
    repeat (2) @(negedge CLK28M);
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK28M);
    test_single_write("midreset_write", 1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_idle();
    test_single_write("single", 11);
    test_fill_overflow();
    test_full_pop();
    test_line_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
